// File: rtl/dmem_pkg.sv
// Shared types and byte-lane helpers for the MEM-stage data memory.
package dmem_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned LANES  = 4;

  typedef enum logic [1:0] {
    MS_BYTE = 2'b00,
    MS_HALF = 2'b01,
    MS_WORD = 2'b10,
    MS_RSVD = 2'b11
  } mem_size_e;

  typedef enum logic {
    CLEAR = 1'b0,
    IDLE  = 1'b1
  } dmem_state_e;

  // Reserved size always counts as misaligned so it can never touch memory.
  function automatic logic is_misaligned(input mem_size_e size, input logic [1:0] lo);
    logic bad;
    case (size)
      MS_BYTE: bad = 1'b0;
      MS_HALF: bad = lo[0];
      MS_WORD: bad = |lo;
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

  function automatic logic [LANES-1:0] lane_be(input mem_size_e size, input logic [1:0] lo);
    logic [LANES-1:0] be;
    case (size)
      MS_BYTE: be = 4'b0001 << lo;
      MS_HALF: be = 4'b0011 << lo;
      MS_WORD: be = 4'b1111;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational lane steering: store byte-enable merge and load extract with sign/zero extension.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [1:0]        addr_lo_i,
  input  mem_size_e         size_i,
  input  logic              unsigned_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [DATA_W-1:0] word_i,
  output logic [DATA_W-1:0] merged_c_o,
  output logic [DATA_W-1:0] rdata_c_o
);

  logic [LANES-1:0]  be;
  logic [DATA_W-1:0] wrep;
  logic [15:0]       shifted;

  always_comb begin
    be = lane_be(size_i, addr_lo_i);
    case (size_i)
      MS_BYTE: wrep = {4{wdata_i[7:0]}};
      MS_HALF: wrep = {2{wdata_i[15:0]}};
      default: wrep = wdata_i;
    endcase
    merged_c_o = word_i;
    for (int k = 0; k < LANES; k++) begin
      if (be[k]) merged_c_o[8*k +: 8] = wrep[8*k +: 8];
    end
  end

  // Addressed lane is shifted down to bit 0 before extension.
  always_comb begin
    shifted = 16'(word_i >> {addr_lo_i, 3'b000});
    case (size_i)
      MS_BYTE: rdata_c_o = unsigned_i ? {24'b0, shifted[7:0]} : {{24{shifted[7]}}, shifted[7:0]};
      MS_HALF: rdata_c_o = unsigned_i ? {16'b0, shifted} : {{16{shifted[15]}}, shifted};
      default: rdata_c_o = word_i;
    endcase
  end

endmodule

// File: rtl/data_memory_be.sv
// Byte-addressed MIPS data memory with sized loads/stores, error pulses and clear-after-reset.
module data_memory_be
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH    = 256,
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned CLR_INIT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] write_data,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic              MemtoReg,
  input  logic [1:0]        mem_size,
  input  logic              mem_unsigned,
  output logic              ready,
  output logic              read_valid,
  output logic              misalign,
  output logic              range_err,
  output logic [DATA_W-1:0] read_data
);

  localparam int unsigned IDX_W = $clog2(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];

  dmem_state_e       state_q, state_d;
  logic [IDX_W-1:0]  clr_ptr_q, clr_ptr_d;
  logic              ready_q, ready_d;
  logic              read_valid_q, read_valid_d;
  logic              misalign_q, misalign_d;
  logic              range_err_q, range_err_d;
  logic [DATA_W-1:0] load_q, load_d;

  logic [IDX_W-1:0]  idx, mem_widx;
  logic              out_of_range, bad_align, mem_we;
  logic [DATA_W-1:0] old_word, merged, extracted, mem_wdata;
  mem_size_e         size;

  assign size         = mem_size_e'(mem_size);
  assign idx          = address[IDX_W+1:2];
  assign out_of_range = |address[ADDR_W-1:IDX_W+2];
  assign bad_align    = is_misaligned(size, address[1:0]);
  assign old_word     = mem_q[idx];

  dmem_lane_align u_lane_align (
    .addr_lo_i  (address[1:0]),
    .size_i     (size),
    .unsigned_i (mem_unsigned),
    .wdata_i    (write_data),
    .word_i     (old_word),
    .merged_c_o (merged),
    .rdata_c_o  (extracted)
  );

  always_comb begin
    state_d      = state_q;
    clr_ptr_d    = clr_ptr_q;
    read_valid_d = 1'b0;
    misalign_d   = 1'b0;
    range_err_d  = 1'b0;
    load_d       = load_q;
    mem_we       = 1'b0;
    mem_widx     = idx;
    mem_wdata    = merged;
    case (state_q)
      CLEAR: begin
        mem_we    = 1'b1;
        mem_widx  = clr_ptr_q;
        mem_wdata = '0;
        clr_ptr_d = clr_ptr_q + IDX_W'(1);
        if (clr_ptr_q == IDX_W'(DEPTH - 1)) state_d = IDLE;
      end
      default: begin
        // Misalignment outranks range; loads read the array before this edge's write.
        if (ready_q && (MemRead || MemWrite)) begin
          if (bad_align) begin
            misalign_d = 1'b1;
          end else if (out_of_range) begin
            range_err_d = 1'b1;
            if (MemRead) load_d = '0;
          end else begin
            mem_we = MemWrite;
            if (MemRead) begin
              load_d       = extracted;
              read_valid_d = 1'b1;
            end
          end
        end
      end
    endcase
    ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= (CLR_INIT != 0) ? CLEAR : IDLE;
      clr_ptr_q    <= '0;
      ready_q      <= 1'b0;
      read_valid_q <= 1'b0;
      misalign_q   <= 1'b0;
      range_err_q  <= 1'b0;
      load_q       <= '0;
    end else begin
      state_q      <= state_d;
      clr_ptr_q    <= clr_ptr_d;
      ready_q      <= ready_d;
      read_valid_q <= read_valid_d;
      misalign_q   <= misalign_d;
      range_err_q  <= range_err_d;
      load_q       <= load_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem_q[mem_widx] <= mem_wdata;
  end

  assign ready      = ready_q;
  assign read_valid = read_valid_q;
  assign misalign   = misalign_q;
  assign range_err  = range_err_q;
  assign read_data  = !rst ? '0 : (MemtoReg ? load_q : DATA_W'(address));

endmodule
